naive_bus_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one naive_bus slave port among `N_MASTERS` requesters, such as the core's instruction master, its data master and a debug/DMA master. It selects one request per cycle and forwards grants combinationally. Once a request has been presented, it keeps the selection locked until the slave grants it, so the slave never sees an address change under a stall. It registers the read owner so that read data, which arrives one cycle after the grant, is steered only to the master that issued the read.

---
 rtl/naive_bus_pkg.sv | 20 ++
 rtl/naive_bus_rr_arbiter_rr_pick.sv | 40 ++++
 rtl/naive_bus_rr_arbiter.sv | 157 +++++++++++++++
 tb/tb_naive_bus_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/naive_bus_pkg.sv
// ============================================================================
// naive_bus_pkg : shared bus widths and arbiter state encoding
// Revision      : 1.0
// ============================================================================
`default_nettype none

package naive_bus_pkg;

   localparam int BUS_AW  = 32;
   localparam int BUS_DW  = 32;
   localparam int BUS_BEW = 4;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/naive_bus_rr_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : first set request found scanning upward from a rotating pointer
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
   import naive_bus_pkg::*;
#(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] idx,
   output logic          valid
);

   // One spare bit so ptr+k can exceed N before being folded back.
   logic [PW:0] cand;

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr} + (PW+1)'(k);
         if (cand >= (PW+1)'(N)) begin
            cand = cand - (PW+1)'(N);
         end
         if (!valid && req[cand[PW-1:0]]) begin
            valid = 1'b1;
            idx   = cand[PW-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/naive_bus_rr_arbiter.sv
// ============================================================================
// naive_bus_rr_arbiter : round-robin share of one naive_bus slave, with
//                        stall lock and registered read-data owner
// Revision             : 1.0
// ============================================================================
`default_nettype none

module naive_bus_rr_arbiter
   import naive_bus_pkg::*;
#(
   parameter int N_MASTERS = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N_MASTERS-1:0]           m_rd_req,
   input  logic [N_MASTERS*BUS_AW-1:0]    m_rd_addr,
   output logic [N_MASTERS-1:0]           m_rd_gnt,
   output logic [N_MASTERS*BUS_DW-1:0]    m_rd_data,
   input  logic [N_MASTERS-1:0]           m_wr_req,
   input  logic [N_MASTERS*BUS_AW-1:0]    m_wr_addr,
   input  logic [N_MASTERS*BUS_BEW-1:0]   m_wr_byte_mask,
   input  logic [N_MASTERS*BUS_DW-1:0]    m_wr_data,
   output logic [N_MASTERS-1:0]           m_wr_gnt,
   output logic                           s_rd_req,
   output logic [BUS_AW-1:0]              s_rd_addr,
   input  logic                           s_rd_gnt,
   input  logic [BUS_DW-1:0]              s_rd_data,
   output logic                           s_wr_req,
   output logic [BUS_AW-1:0]              s_wr_addr,
   output logic [BUS_BEW-1:0]             s_wr_byte_mask,
   output logic [BUS_DW-1:0]              s_wr_data,
   input  logic                           s_wr_gnt
);

   localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   arb_state_e          state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [PW-1:0]       lock_idx_q, lock_idx_d;
   logic                lock_rd_q, lock_rd_d;
   logic                own_v_q, own_v_d;
   logic [PW-1:0]       own_idx_q, own_idx_d;

   logic [N_MASTERS-1:0] any_req;
   logic [PW-1:0]        pick_idx;
   logic                 pick_valid;
   logic [PW-1:0]        sel;
   logic [PW-1:0]        sel_inc;
   logic                 sel_v;
   logic                 pres_rd;
   logic                 rd_gnt;
   logic                 wr_gnt;

   logic [BUS_AW-1:0]    rd_addr_a [N_MASTERS];
   logic [BUS_AW-1:0]    wr_addr_a [N_MASTERS];
   logic [BUS_DW-1:0]    wr_data_a [N_MASTERS];
   logic [BUS_BEW-1:0]   wr_mask_a [N_MASTERS];

   assign any_req = m_rd_req | m_wr_req;

   rr_pick #(
      .N  (N_MASTERS),
      .PW (PW)
   ) u_rr_pick (
      .req   (any_req),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // A locked master stays selected only while it holds the locked type;
   // nothing is presented while reset is asserted.
   always_comb begin
      sel     = pick_idx;
      pres_rd = m_rd_req[pick_idx];
      sel_v   = pick_valid;
      if (state_q == ARB_LOCK) begin
         sel     = lock_idx_q;
         pres_rd = lock_rd_q;
         sel_v   = lock_rd_q ? m_rd_req[lock_idx_q] : m_wr_req[lock_idx_q];
      end
      sel_v = sel_v & rst_n;
   end

   assign sel_inc        = (sel == PW'(N_MASTERS - 1)) ? '0 : sel + 1'b1;
   assign s_rd_req       = sel_v & pres_rd;
   assign s_wr_req       = sel_v & ~pres_rd;
   assign s_rd_addr      = s_rd_req ? rd_addr_a[sel] : '0;
   assign s_wr_addr      = s_wr_req ? wr_addr_a[sel] : '0;
   assign s_wr_data      = s_wr_req ? wr_data_a[sel] : '0;
   assign s_wr_byte_mask = s_wr_req ? wr_mask_a[sel] : '0;
   assign rd_gnt         = s_rd_req & s_rd_gnt;
   assign wr_gnt         = s_wr_req & s_wr_gnt;

   for (genvar i = 0; i < N_MASTERS; i++) begin : g_master
      assign rd_addr_a[i] = m_rd_addr[BUS_AW*i +: BUS_AW];
      assign wr_addr_a[i] = m_wr_addr[BUS_AW*i +: BUS_AW];
      assign wr_data_a[i] = m_wr_data[BUS_DW*i +: BUS_DW];
      assign wr_mask_a[i] = m_wr_byte_mask[BUS_BEW*i +: BUS_BEW];
      assign m_rd_gnt[i]  = rd_gnt & (sel == PW'(i));
      assign m_wr_gnt[i]  = wr_gnt & (sel == PW'(i));
      assign m_rd_data[BUS_DW*i +: BUS_DW] =
         (own_v_q && (own_idx_q == PW'(i))) ? s_rd_data : '0;
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      lock_idx_d = lock_idx_q;
      lock_rd_d  = lock_rd_q;
      own_v_d    = rd_gnt;
      own_idx_d  = rd_gnt ? sel : own_idx_q;
      case (state_q)
         ARB_IDLE: begin
            if (sel_v) begin
               if (rd_gnt || wr_gnt) begin
                  ptr_d = sel_inc;
               end else begin
                  lock_idx_d = sel;
                  lock_rd_d  = pres_rd;
                  state_d    = ARB_LOCK;
               end
            end
         end
         ARB_LOCK: begin
            if (!sel_v) begin
               state_d = ARB_IDLE;
            end else if (rd_gnt || wr_gnt) begin
               ptr_d   = sel_inc;
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB_IDLE;
         ptr_q      <= '0;
         lock_idx_q <= '0;
         lock_rd_q  <= 1'b0;
         own_v_q    <= 1'b0;
         own_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         lock_idx_q <= lock_idx_d;
         lock_rd_q  <= lock_rd_d;
         own_v_q    <= own_v_d;
         own_idx_q  <= own_idx_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_naive_bus_rr_arbiter.sv
// ============================================================================
// tb_naive_bus_rr_arbiter : directed scenarios plus random traffic against a
//                           behavioural model of the round-robin arbiter
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_naive_bus_rr_arbiter;

   localparam int N = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]    m_rd_req = '0;
   logic [N*32-1:0] m_rd_addr = '0;
   logic [N-1:0]    m_rd_gnt;
   logic [N*32-1:0] m_rd_data;
   logic [N-1:0]    m_wr_req = '0;
   logic [N*32-1:0] m_wr_addr = '0;
   logic [N*4-1:0]  m_wr_byte_mask = '0;
   logic [N*32-1:0] m_wr_data = '0;
   logic [N-1:0]    m_wr_gnt;
   logic          s_rd_req;
   logic [31:0]   s_rd_addr;
   logic          s_rd_gnt = 1'b0;
   logic [31:0]   s_rd_data = '0;
   logic          s_wr_req;
   logic [31:0]   s_wr_addr;
   logic [3:0]    s_wr_byte_mask;
   logic [31:0]   s_wr_data;
   logic          s_wr_gnt = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   naive_bus_rr_arbiter #(.N_MASTERS(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_gnt(m_rd_gnt),
      .m_rd_data(m_rd_data), .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr),
      .m_wr_byte_mask(m_wr_byte_mask), .m_wr_data(m_wr_data), .m_wr_gnt(m_wr_gnt),
      .s_rd_req(s_rd_req), .s_rd_addr(s_rd_addr), .s_rd_gnt(s_rd_gnt),
      .s_rd_data(s_rd_data), .s_wr_req(s_wr_req), .s_wr_addr(s_wr_addr),
      .s_wr_byte_mask(s_wr_byte_mask), .s_wr_data(s_wr_data), .s_wr_gnt(s_wr_gnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model state: rotation pointer, pending (stalled) master or -1, last read owner or -1.
   int       md_ptr = 0;
   int       md_lock = -1;
   bit       md_lock_rd = 1'b0;
   int       md_own = -1;
   logic [N-1:0] e_rgnt = '0;
   logic [N-1:0] e_wgnt = '0;

   always @(negedge clk) begin
      int          sel;
      bit          rd;
      bit          g;
      logic [95:0] e_rdata;
      sel = -1;
      rd = 1'b0;
      g = 1'b0;
      e_rdata = '0;
      if (!rst_n) begin
         md_ptr = 0;
         md_lock = -1;
         md_own = -1;
      end else begin
         if (md_own >= 0) e_rdata[32*md_own +: 32] = s_rd_data;
         if (md_lock >= 0) begin
            if (md_lock_rd ? m_rd_req[md_lock] : m_wr_req[md_lock]) begin
               sel = md_lock;
               rd  = md_lock_rd;
            end
         end else begin
            for (int k = 0; k < N; k++) begin
               int c;
               c = (md_ptr + k) % N;
               if (sel < 0 && (m_rd_req[c] || m_wr_req[c])) begin
                  sel = c;
                  rd  = m_rd_req[c];
               end
            end
         end
      end
      if (sel >= 0) g = rd ? s_rd_gnt : s_wr_gnt;
      e_rgnt = (sel >= 0 && rd && g)  ? N'(1 << sel) : '0;
      e_wgnt = (sel >= 0 && !rd && g) ? N'(1 << sel) : '0;

      chk("s_rd_req", s_rd_req, sel >= 0 && rd);
      chk("s_wr_req", s_wr_req, sel >= 0 && !rd);
      chk("s_rd_addr", s_rd_addr, (sel >= 0 && rd) ? m_rd_addr[32*sel +: 32] : 32'h0);
      chk("s_wr_addr", s_wr_addr, (sel >= 0 && !rd) ? m_wr_addr[32*sel +: 32] : 32'h0);
      chk("s_wr_data", s_wr_data, (sel >= 0 && !rd) ? m_wr_data[32*sel +: 32] : 32'h0);
      chk("s_wr_mask", s_wr_byte_mask, (sel >= 0 && !rd) ? m_wr_byte_mask[4*sel +: 4] : 4'h0);
      chk("m_rd_gnt", m_rd_gnt, e_rgnt);
      chk("m_wr_gnt", m_wr_gnt, e_wgnt);
      chk("m_rd_data", m_rd_data, e_rdata);

      if (rst_n) begin
         if (sel >= 0 && g) begin
            md_ptr  = (sel + 1) % N;
            md_lock = -1;
         end else if (sel >= 0) begin
            md_lock    = sel;
            md_lock_rd = rd;
         end else begin
            md_lock = -1;
         end
         md_own = (sel >= 0 && rd && g) ? sel : -1;
      end
   end

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic to_check();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m_rd_req = '0; m_wr_req = '0;
      s_rd_gnt = 1'b0; s_wr_gnt = 1'b0; s_rd_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      to_drive();
      rst_n = 1'b1;
   endtask

   logic [N-1:0] fair_exp [6];

   initial begin
      fair_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

      // Reset state
      to_check();
      chk("rst_outputs", {s_rd_req, s_wr_req, m_rd_gnt, m_wr_gnt, s_rd_addr, s_wr_addr}, '0);
      chk("rst_rdata", m_rd_data, '0);
      to_drive();
      rst_n = 1'b1;

      // Single master read with next-cycle data
      m_rd_req = 3'b010; m_rd_addr[63:32] = 32'h0000_0010; s_rd_gnt = 1'b1;
      to_check();
      chk("single_gnt", m_rd_gnt, 3'b010);
      chk("single_addr", s_rd_addr, 32'h0000_0010);
      to_drive();
      idle_inputs(); s_rd_data = 32'hDEAD_BEEF;
      to_check();
      chk("single_data", m_rd_data, {32'h0, 32'hDEAD_BEEF, 32'h0});

      // Fairness with all masters reading
      to_drive();
      do_reset();
      m_rd_req = 3'b111; s_rd_gnt = 1'b1;
      for (int i = 0; i < 6; i++) begin
         to_check();
         chk("fair_gnt", m_rd_gnt, fair_exp[i]);
         to_drive();
      end

      // Stall lock: master 0 write held while master 2 also requests
      do_reset();
      m_wr_req[0] = 1'b1; m_wr_addr[31:0] = 32'h1000; m_wr_data[31:0] = 32'h55AA_55AA;
      m_wr_byte_mask[3:0] = 4'hF; m_rd_req[2] = 1'b1; m_rd_addr[95:64] = 32'h2000;
      for (int i = 0; i < 4; i++) begin
         to_check();
         chk("stall_addr", s_wr_addr, 32'h1000);
         chk("stall_nogrant", {m_rd_gnt, m_wr_gnt}, 6'b0);
         to_drive();
      end
      s_wr_gnt = 1'b1; s_rd_gnt = 1'b1;
      to_check();
      chk("stall_gnt0", m_wr_gnt, 3'b001);
      to_drive();
      m_wr_req[0] = 1'b0;
      to_check();
      chk("stall_gnt2", m_rd_gnt, 3'b100);
      to_drive();

      // Read+write on the same master: read first, write later
      do_reset();
      m_rd_req[2] = 1'b1; m_wr_req[2] = 1'b1; s_rd_gnt = 1'b1; s_wr_gnt = 1'b1;
      to_check();
      chk("rw_rd_first", {m_rd_gnt, m_wr_gnt}, {3'b100, 3'b000});
      to_drive();
      m_rd_req[2] = 1'b0;
      to_check();
      chk("rw_wr_later", {m_rd_gnt, m_wr_gnt}, {3'b000, 3'b100});
      to_drive();

      // Back-to-back read data steering
      do_reset();
      m_rd_req = 3'b011; s_rd_gnt = 1'b1;
      to_check();
      chk("b2b_gnt0", m_rd_gnt, 3'b001);
      to_drive();
      m_rd_req = 3'b010; s_rd_data = 32'h1111_1111;
      to_check();
      chk("b2b_gnt1", m_rd_gnt, 3'b010);
      chk("b2b_data0", m_rd_data, {32'h0, 32'h0, 32'h1111_1111});
      to_drive();
      m_rd_req = 3'b000; s_rd_data = 32'h2222_2222;
      to_check();
      chk("b2b_data1", m_rd_data, {32'h0, 32'h2222_2222, 32'h0});
      to_drive();

      // Reset while locked on a stalled request
      do_reset();
      m_rd_req = 3'b010; s_rd_gnt = 1'b0;
      to_drive();
      rst_n = 1'b0; s_rd_gnt = 1'b1;
      to_check();
      chk("rstlock_out", {s_rd_req, s_rd_addr, m_rd_gnt, m_wr_gnt, s_wr_req}, '0);
      to_drive();
      rst_n = 1'b1; m_rd_req = 3'b111;
      to_check();
      chk("rstlock_restart", m_rd_gnt, 3'b001);
      to_drive();

      // Random traffic: pending requests mostly held until granted
      idle_inputs();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            bit pending;
            pending = (m_rd_req[i] && !e_rgnt[i]) || (m_wr_req[i] && !e_wgnt[i]);
            if (!(pending && $urandom_range(9) != 0)) begin
               m_rd_req[i] = ($urandom_range(2) == 0);
               m_wr_req[i] = ($urandom_range(2) == 0);
               m_rd_addr[32*i +: 32] = $urandom;
               m_wr_addr[32*i +: 32] = $urandom;
               m_wr_data[32*i +: 32] = $urandom;
               m_wr_byte_mask[4*i +: 4] = 4'($urandom);
            end
         end
         s_rd_gnt  = ($urandom_range(3) != 0);
         s_wr_gnt  = ($urandom_range(3) != 0);
         s_rd_data = $urandom;
         rst_n     = ($urandom_range(299) != 0);
         to_drive();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
